// File: rtl/procesador_pkg.sv
// Shared definitions for the 8-bit pipelined processor front end.
// Provides the default address/instruction widths, the fetch FSM state
// encoding and the all-zero NOP instruction used for an empty queue head.
package procesador_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/prefetch_fifo.sv
// Instruction prefetch queue storage.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset (pointers/count only)
//   clear        : synchronous flush, empties the queue (wins over push/pop)
//   push, wdata  : write {instruction, pc} at the tail
//   pop          : advance the head (only when valid)
//   rdata, valid : head entry and non-empty flag
//   count        : current occupancy, 0..DEPTH
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is data only; occupancy decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one-at-a-time word
// requests to a variable-latency instruction memory and queues the returned
// instructions for the IF/ID register. A redirect flushes the queue and marks
// any in-flight response as stale.
// Optional build macro: PREFETCH_BYPASS_EN (response forwarded to the head
// outputs in the same cycle when the queue is empty).
// Ports:
//   Clock, Reset           : rising-edge clock, asynchronous active-low reset
//   iRedirect, iRedirectPC : taken branch/jump and its target
//   iStall                 : suppresses new requests
//   oMemReq, oMemAddr      : registered one-cycle request pulse and address
//   iMemValid, iMemData    : memory response
//   oValid, iReady         : head handshake towards IF/ID
//   oInstruction, oPC      : head instruction and its address
//   oPCNext                : oPC + 1 (wrapping)
module instr_prefetch_queue
  import procesador_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = procesador_pkg::ADDR_W,
  parameter int                INSTR_W  = procesador_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iRedirect,
  input  logic [ADDR_W-1:0]  iRedirectPC,
  input  logic               iStall,
  output logic               oMemReq,
  output logic [ADDR_W-1:0]  oMemAddr,
  input  logic               iMemValid,
  input  logic [INSTR_W-1:0] iMemData,
  output logic               oValid,
  input  logic               iReady,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic [ADDR_W-1:0]  oPCNext
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = INSTR_W + ADDR_W;

  fetch_state_t        state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ENT_W-1:0]    fifo_rdata;
  logic                fifo_valid;
  logic [CNT_W-1:0]    count;
  logic                issue;
  logic                resp_live;
  logic                push;
  logic                pop;

  // Room is checked while no request is outstanding, so the queue cannot overflow.
  assign issue     = (state == IDLE) && (count < CNT_W'(DEPTH)) && !iStall && !iRedirect;
  // oMemAddr holds the outstanding request address until the response returns.
  assign resp_live = (state == WAIT) && iMemValid && !iRedirect;
  assign pop       = fifo_valid && iReady && !iRedirect;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass       = !fifo_valid && (state == WAIT) && iMemValid;
  assign oValid       = fifo_valid || bypass;
  assign oInstruction = fifo_valid ? fifo_rdata[ENT_W-1:ADDR_W]
                      : (bypass ? iMemData : INSTR_W'(NOP_INSTR));
  assign oPC          = fifo_valid ? fifo_rdata[ADDR_W-1:0]
                      : (bypass ? oMemAddr : '0);
  // A forwarded response that is taken immediately never enters the queue.
  assign push         = resp_live && !(bypass && iReady);
`else
  assign oValid       = fifo_valid;
  assign oInstruction = fifo_valid ? fifo_rdata[ENT_W-1:ADDR_W] : INSTR_W'(NOP_INSTR);
  assign oPC          = fifo_valid ? fifo_rdata[ADDR_W-1:0] : '0;
  assign push         = resp_live;
`endif

  assign oPCNext = oPC + ADDR_W'(1);

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .clear (iRedirect),
    .push  (push),
    .wdata ({iMemData, oMemAddr}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (count)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      oMemReq  <= 1'b0;
      oMemAddr <= '0;
    end else begin
      oMemReq <= issue;
      if (issue) begin
        oMemAddr <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (iRedirect) fetch_pc <= iRedirectPC;

      case (state)
        IDLE:    if (issue) state <= WAIT;
        // A response coinciding with a redirect is dropped but still ends the wait.
        WAIT:    if (iMemValid) state <= IDLE;
                 else if (iRedirect) state <= DISCARD;
        DISCARD: if (iMemValid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
